// File: rtl/imem_loader_if.sv
// Handshake and memory-port bundle between the byte source, the program
// loader and the core's instruction memory / reset.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        reload;
  logic [31:0] imem_din;
  logic [31:0] imem_addr;
  logic        imem_web;
  logic        core_rstn;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  // master: byte source / supervisor side; slave: the loader itself
  modport master (
    output rx_data, rx_valid, reload,
    input  rx_ready, imem_din, imem_addr, imem_web, core_rstn,
           busy, done, error, words_written
  );

  modport slave (
    input  rx_data, rx_valid, reload,
    output rx_ready, imem_din, imem_addr, imem_web, core_rstn,
           busy, done, error, words_written
  );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: assembles little-endian words, writes them
// to instruction memory and holds the core in reset until a valid frame lands.
module imem_loader #(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input logic         clk,
  input logic         rstn,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int unsigned   TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   MAX_N   = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] ww_q, ww_d;
  logic [TO_W-1:0] to_q, to_d;
  logic        web_q, web_d;
  logic        core_rstn_q, core_rstn_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        rx_ready;
  logic        take;
  logic        timed;
  logic [15:0] len_full;

  assign rx_ready = (state_q == S_IDLE) || (state_q == S_LEN_HI) ||
                    (state_q == S_DATA) || (state_q == S_CSUM);
  assign take     = bus.rx_valid && rx_ready;
  assign timed    = (state_q == S_LEN_HI) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign len_full = {bus.rx_data, len_q[7:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      csum_q      <= '0;
      addr_q      <= ADDR_BASE;
      ww_q        <= '0;
      to_q        <= '0;
      web_q       <= 1'b1;
      core_rstn_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      addr_q      <= addr_d;
      ww_q        <= ww_d;
      to_q        <= to_d;
      web_q       <= web_d;
      core_rstn_q <= core_rstn_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    word_d  = word_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    ww_d    = ww_q;
    to_d    = to_q;

    case (state_q)
      S_IDLE: begin
        if (take) begin
          len_d[7:0] = bus.rx_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (take) begin
          len_d[15:8] = bus.rx_data;
          idx_d       = 2'd0;
          if ({1'b0, len_full} > MAX_N) begin
            state_d = S_ERROR;
          end else if (len_full == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (take) begin
          word_d[idx_q*8 +: 8] = bus.rx_data;
          csum_d               = csum_q + bus.rx_data;
          idx_d                = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 32'd4;
        ww_d    = ww_q + 16'd1;
        state_d = ((ww_q + 16'd1) == len_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (take) begin
          state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERROR;
        end
      end
      S_DONE, S_ERROR: begin
        // Rearm for a fresh frame; memory contents are left untouched.
        if (bus.reload) begin
          state_d = S_IDLE;
          ww_d    = '0;
          addr_d  = ADDR_BASE;
          csum_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte watchdog; only the waiting states can stall.
    if (timed && !take) begin
      if (to_q == TO_LAST) begin
        state_d = S_ERROR;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
    if (take || (state_d != state_q)) begin
      to_d = '0;
    end
  end

  // Memory strobe and status are registered from the next state so the core
  // sees glitch-free signals that change on the same edge as the FSM.
  always_comb begin
    web_d       = (state_d != S_WRITE);
    core_rstn_d = (state_d == S_DONE);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERROR);
  end

  assign bus.rx_ready      = rx_ready;
  assign bus.imem_din      = word_q;
  assign bus.imem_addr     = addr_q;
  assign bus.imem_web      = web_q;
  assign bus.core_rstn     = core_rstn_q;
  assign bus.busy          = (state_q == S_LEN_HI) || (state_q == S_DATA) ||
                             (state_q == S_WRITE)  || (state_q == S_CSUM);
  assign bus.done          = done_q;
  assign bus.error         = error_q;
  assign bus.words_written = ww_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames
// checked against a frame-level model of expected writes and outcome.
module tb_imem_loader;
  localparam int TO   = 40;
  localparam int MAXW = 1024;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if bus ();

  imem_loader #(
    .ADDR_BASE     (32'h0000_0000),
    .MAX_WORDS     (MAXW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] cap_addr[$];
  logic [31:0] cap_word[$];
  logic [7:0]  pay_q[$];

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Write monitor: every cycle with the strobe low is one memory write.
  always @(negedge clk) begin
    if (rstn && bus.imem_web === 1'b0) begin
      cap_addr.push_back(bus.imem_addr);
      cap_word.push_back(bus.imem_din);
      chk1("ready_low_in_write", bus.rx_ready, 1'b0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    @(negedge clk);
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      chk1("ready_wait", bus.rx_ready, 1'b1);
      bus.rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_bus(input int k);
    bus.rx_valid = 1'b0;
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic reload_pulse(input string tag);
    @(negedge clk);
    bus.reload = 1'b1;
    @(posedge clk);
    #1;
    bus.reload = 1'b0;
    chk1({tag, "_rl_busy"}, bus.busy, 1'b0);
    chk1({tag, "_rl_done"}, bus.done, 1'b0);
    chk1({tag, "_rl_error"}, bus.error, 1'b0);
    chk1({tag, "_rl_core_rstn"}, bus.core_rstn, 1'b0);
    chk1({tag, "_rl_ready"}, bus.rx_ready, 1'b1);
    chk32({tag, "_rl_ww"}, 32'(bus.words_written), 32'd0);
    chk32({tag, "_rl_addr"}, bus.imem_addr, 32'd0);
  endtask

  // One frame: model derives writes, checksum and outcome from the frame rules.
  task automatic run_frame(input logic [15:0] n, input logic [7:0] csum_delta,
                           input bit fixed, input int max_gap, input string tag);
    logic [7:0]  sum = 8'd0;
    logic [7:0]  csum;
    logic        ok;
    logic [31:0] w;
    int          nw = int'(n);
    cap_addr.delete();
    cap_word.delete();
    if (!fixed) begin
      pay_q.delete();
      if (nw <= MAXW) for (int i = 0; i < nw * 4; i++) pay_q.push_back(8'($urandom));
    end
    foreach (pay_q[i]) sum += pay_q[i];
    csum = sum + csum_delta;
    ok   = (nw <= MAXW) && (csum_delta == 8'd0);

    send_byte(n[7:0], $urandom_range(0, max_gap));
    send_byte(n[15:8], $urandom_range(0, max_gap));
    if (nw > MAXW) begin
      chk1({tag, "_lenerr_error"}, bus.error, 1'b1);
      chk1({tag, "_lenerr_ready"}, bus.rx_ready, 1'b0);
      idle_bus(3);
      chk32({tag, "_lenerr_writes"}, 32'(cap_addr.size()), 32'd0);
      chk1({tag, "_lenerr_core_rstn"}, bus.core_rstn, 1'b0);
      chk32({tag, "_lenerr_ww"}, 32'(bus.words_written), 32'd0);
      return;
    end
    foreach (pay_q[i]) send_byte(pay_q[i], $urandom_range(0, max_gap));
    send_byte(csum, $urandom_range(0, max_gap));
    chk1({tag, "_core_rstn_edge"}, bus.core_rstn, ok);
    idle_bus(2);
    chk32({tag, "_writes"}, 32'(cap_addr.size()), 32'(nw));
    for (int k = 0; k < nw && k < cap_addr.size(); k++) begin
      w = {pay_q[4*k+3], pay_q[4*k+2], pay_q[4*k+1], pay_q[4*k]};
      chk32($sformatf("%s_addr%0d", tag, k), cap_addr[k], 32'(4 * k));
      chk32($sformatf("%s_word%0d", tag, k), cap_word[k], w);
    end
    chk1({tag, "_done"}, bus.done, ok);
    chk1({tag, "_error"}, bus.error, !ok);
    chk32({tag, "_ww"}, 32'(bus.words_written), 32'(nw));
    chk1({tag, "_busy"}, bus.busy, 1'b0);
    chk1({tag, "_ready"}, bus.rx_ready, 1'b0);
    chk32({tag, "_end_addr"}, bus.imem_addr, 32'(4 * nw));
  endtask

  initial begin
    logic [15:0] n;
    logic [7:0]  d;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.reload   = 1'b0;

    // Reset state, and bytes offered during reset are ignored.
    repeat (2) @(posedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    chk1("rst_web", bus.imem_web, 1'b1);
    chk32("rst_din", bus.imem_din, 32'd0);
    chk32("rst_addr", bus.imem_addr, 32'd0);
    chk1("rst_core_rstn", bus.core_rstn, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk1("rst_error", bus.error, 1'b0);
    chk32("rst_ww", 32'(bus.words_written), 32'd0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_ready", bus.rx_ready, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk1("post_rst_busy", bus.busy, 1'b0);

    // Single word 0x13 with matching checksum.
    pay_q = '{8'h13, 8'h00, 8'h00, 8'h00};
    run_frame(16'd1, 8'd0, 1'b1, 0, "one_word");
    if (cap_word.size() > 0) chk32("one_word_din", cap_word[0], 32'h0000_0013);
    reload_pulse("one_word");

    // Two words, rx_valid held high throughout.
    run_frame(16'd2, 8'd0, 1'b0, 0, "two_word");
    reload_pulse("two_word");

    // Bad checksum (0x14), then recovery with a good frame.
    pay_q = '{8'h13, 8'h00, 8'h00, 8'h00};
    run_frame(16'd1, 8'd1, 1'b1, 0, "bad_csum");
    reload_pulse("bad_csum");
    run_frame(16'd3, 8'd0, 1'b0, 2, "recover");
    reload_pulse("recover");

    // Empty frame.
    pay_q.delete();
    run_frame(16'd0, 8'd0, 1'b1, 1, "empty");
    reload_pulse("empty");

    // Word count one above the limit.
    run_frame(16'h0401, 8'd0, 1'b0, 0, "too_long");
    reload_pulse("too_long");

    // Stall mid-DATA until the inter-byte watchdog fires.
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 0);
    bus.rx_valid = 1'b0;
    repeat (TO - 2) @(posedge clk);
    #1;
    chk1("timeout_early_error", bus.error, 1'b0);
    chk1("timeout_early_busy", bus.busy, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk1("timeout_error", bus.error, 1'b1);
    chk1("timeout_busy", bus.busy, 1'b0);
    chk1("timeout_core_rstn", bus.core_rstn, 1'b0);
    reload_pulse("timeout");

    // Asynchronous reset in the middle of the second payload word.
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
    chk32("midrst_ww_before", 32'(bus.words_written), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk1("midrst_busy", bus.busy, 1'b0);
    chk1("midrst_web", bus.imem_web, 1'b1);
    chk1("midrst_core_rstn", bus.core_rstn, 1'b0);
    chk1("midrst_ready", bus.rx_ready, 1'b1);
    chk32("midrst_ww", 32'(bus.words_written), 32'd0);
    chk32("midrst_addr", bus.imem_addr, 32'd0);
    bus.rx_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    run_frame(16'd2, 8'd0, 1'b0, 1, "after_rst");

    // Asynchronous reset while DONE drops the core reset immediately.
    #2;
    rstn = 1'b0;
    #1;
    chk1("donerst_core_rstn", bus.core_rstn, 1'b0);
    chk1("donerst_done", bus.done, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    // Randomized frames.
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 7) == 0) n = 16'(1025 + $urandom_range(0, 64000));
      else                           n = 16'($urandom_range(0, 6));
      d = ($urandom_range(0, 3) == 0) ? 8'(1 + $urandom_range(0, 254)) : 8'd0;
      run_frame(n, d, 1'b0, 3, $sformatf("rand%0d", f));
      reload_pulse($sformatf("rand%0d", f));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader directly upstream of the pipelined core top.
- Receives a framed byte stream (e.g. from a UART receiver), assembles little-endian 32-bit words, and writes them into instruction memory through the core's imem_din / imem_addr / imem_web port.
- Holds the core in reset until a complete frame with a valid checksum has been written, then releases it.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte address of the first instruction word written.
- MAX_WORDS, 1024, largest accepted word count; a larger count is a frame error.
- TIMEOUT_CYCLES, 1_000_000, idle cycles allowed between bytes mid-frame before a frame error.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts the byte this cycle
- reload  in  1  single-cycle pulse: restart loading from DONE or ERROR
- imem_din  out  32  instruction word to memory
- imem_addr  out  32  byte address of the write
- imem_web  out  1  active-low instruction-memory write enable
- core_rstn  out  1  active-low reset to the core
- busy  out  1  frame in progress (LEN_HI, DATA, WRITE, CSUM)
- done  out  1  load completed successfully
- error  out  1  frame rejected
- words_written  out  16  words written in the current frame

Behaviour:
- One clock domain. rstn asynchronously clears all flops.
- Reset values:
  - State IDLE.
  - imem_web=1, imem_din=0, imem_addr=ADDR_BASE.
  - core_rstn=0, done=0, error=0, words_written=0.
  - Checksum accumulator 0, timeout counter 0.
- Handshake:
  - A byte transfers on a rising edge where rx_valid && rx_ready.
  - rx_ready is combinational from state: 1 in IDLE, LEN_HI, DATA and CSUM; 0 in WRITE, DONE and ERROR.
  - Bytes presented while rstn=0 are not captured.
- Frame format:
  - LEN_LO, then LEN_HI: 16-bit word count N, little-endian.
  - Then N*4 payload bytes.
  - Then 1 checksum byte = sum of payload bytes modulo 256. Length bytes are excluded.
- FSM:
  - IDLE: on a byte, latch N[7:0] -> LEN_HI.
  - LEN_HI: on a byte, latch N[15:8]. If N > MAX_WORDS -> ERROR. If N == 0 -> CSUM. Otherwise -> DATA with byte index 0.
  - DATA: each byte is shifted into word bits [8*i+7:8*i] for i=0..3 and added to the checksum. The 4th byte -> WRITE.
  - WRITE: lasts exactly one cycle.
    - imem_web=0; imem_din holds the assembled word; imem_addr holds the current address. All three are registered and stable that whole cycle.
    - Next edge: imem_web=1, imem_addr += 4, words_written += 1.
    - Then -> CSUM if words_written (after increment) == N, else -> DATA.
  - CSUM: on a byte, compare it with the accumulator.
    - Equal -> DONE; core_rstn goes 1 on the same edge.
    - Not equal -> ERROR.
  - DONE: done=1, core_rstn=1. Further bytes are not accepted.
  - ERROR: error=1, core_rstn=0. Words already written are left in memory.
  - reload in DONE or ERROR -> IDLE on the next edge. Same edge: core_rstn=0, done=0, error=0, words_written=0, imem_addr=ADDR_BASE, checksum=0. reload in any other state is ignored.
- Timeout:
  - A counter runs in LEN_HI, DATA and CSUM. It clears on every accepted byte and on every state change.
  - Reaching TIMEOUT_CYCLES-1 without a byte -> ERROR.
  - IDLE never times out.
- Arithmetic:
  - imem_addr wraps modulo 2^32.
  - The checksum is 8-bit and wraps.
  - words_written never exceeds N.
- Reset mid-frame: all progress is discarded, FSM returns to IDLE, core_rstn=0 immediately (asynchronous).
- busy=1 exactly in LEN_HI, DATA, WRITE and CSUM.

Test Plan:
- Frame 01 00 | 13 00 00 00 | 13:
  - Exactly one write cycle with imem_web=0, imem_din=32'h0000_0013, imem_addr=0.
  - Then DONE: core_rstn=1, done=1, words_written=1.
- Two-word frame, rx_valid held high continuously:
  - rx_ready=0 during each WRITE cycle; no byte lost.
  - Writes land at addresses 0 and 4 with the correct words.
  - core_rstn rises on the checksum-byte edge.
- Same single-word frame with checksum 14:
  - ERROR, error=1, core_rstn stays 0.
  - reload pulse -> IDLE; then a correct frame loads and reaches DONE.
- Frame 00 00 | 00:
  - No write cycle occurs; DONE.
- Count 0x0401 with MAX_WORDS=1024:
  - ERROR right after LEN_HI; rx_ready=0; no imem_web pulse.
- Boundary cases:
  - Stall TIMEOUT_CYCLES cycles after the 2nd payload byte -> ERROR.
  - Separately, assert rstn=0 mid-DATA -> state IDLE, imem_web=1, core_rstn=0 with no clock edge needed.
